// File: rtl/sprite_scanner.sv
// Per-scanline sprite evaluator: walks all 64 attribute slots after each start
// pulse and streams one record per visible sprite to the line renderer.
module sprite_scanner #(
  parameter int MAX_SPRITES = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] line,
  output logic [5:0] spr_sel,
  input  logic [8:0] spr_x,
  input  logic [7:0] spr_y,
  input  logic [8:0] spr_idx,
  input  logic       spr_enable,
  input  logic       spr_priority,
  input  logic [1:0] spr_palette,
  input  logic       spr_h16,
  input  logic       spr_vflip,
  input  logic       spr_hflip,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [8:0] out_x,
  output logic [8:0] out_idx,
  output logic [2:0] out_row,
  output logic [1:0] out_palette,
  output logic       out_priority,
  output logic       out_hflip,
  output logic       busy,
  output logic       done,
  output logic       overflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e     state_q;
  logic [7:0] line_q;
  logic [5:0] sel_q;
  logic [6:0] count_q;
  logic       overflow_q;
  logic       valid_q;
  logic [8:0] x_q;
  logic [8:0] idx_q;
  logic [2:0] row_q;
  logic [1:0] palette_q;
  logic       priority_q;
  logic       hflip_q;

  logic [7:0] diff_s;
  logic [7:0] height_s;
  logic [3:0] height_m1_s;
  logic [3:0] row_s;
  logic [8:0] idx_s;
  logic       hit_s;
  logic       free_s;
  logic       at_limit_s;

  // Y-range test and row/tile correction for the slot currently on spr_sel.
  always_comb begin
    diff_s      = line_q - spr_y;
    height_s    = spr_h16 ? 8'd16 : 8'd8;
    height_m1_s = spr_h16 ? 4'd15 : 4'd7;
    hit_s       = spr_enable && (diff_s < height_s);
    if (spr_vflip) begin
      row_s = height_m1_s - diff_s[3:0];
    end else begin
      row_s = diff_s[3:0];
    end
    idx_s      = spr_idx + {8'd0, row_s[3]};
    free_s     = !valid_q || out_ready;
    at_limit_s = (count_q == 7'(MAX_SPRITES));
  end

  // Scan sequencer and output record register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      line_q     <= 8'd0;
      sel_q      <= 6'd0;
      count_q    <= 7'd0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
      x_q        <= 9'd0;
      idx_q      <= 9'd0;
      row_q      <= 3'd0;
      palette_q  <= 2'd0;
      priority_q <= 1'b0;
      hflip_q    <= 1'b0;
    end else if (start) begin
      // A restart discards any record still waiting for the renderer.
      state_q    <= SCAN;
      line_q     <= line;
      sel_q      <= 6'd0;
      count_q    <= 7'd0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      if (valid_q && out_ready) begin
        valid_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          state_q <= IDLE;
        end
        SCAN: begin
          if (hit_s && at_limit_s) begin
            overflow_q <= 1'b1;
            state_q    <= DRAIN;
          end else if (hit_s && !free_s) begin
            state_q <= SCAN;
          end else begin
            if (hit_s) begin
              valid_q    <= 1'b1;
              x_q        <= spr_x;
              idx_q      <= idx_s;
              row_q      <= row_s[2:0];
              palette_q  <= spr_palette;
              priority_q <= spr_priority;
              hflip_q    <= spr_hflip;
              count_q    <= count_q + 7'd1;
            end
            if (sel_q == 6'd63) begin
              state_q <= DRAIN;
            end else begin
              sel_q <= sel_q + 6'd1;
            end
          end
        end
        DRAIN: begin
          if (free_s) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // done must coincide with the renderer's final accept, so it follows out_ready.
  assign done         = (state_q == DRAIN) && free_s;
  assign busy         = (state_q != IDLE);
  assign spr_sel      = sel_q;
  assign overflow     = overflow_q;
  assign out_valid    = valid_q;
  assign out_x        = x_q;
  assign out_idx      = idx_q;
  assign out_row      = row_q;
  assign out_palette  = palette_q;
  assign out_priority = priority_q;
  assign out_hflip    = hflip_q;

endmodule

// File: tb/tb_sprite_scanner.sv
// Directed, table-driven bench for sprite_scanner with a behavioural attribute RAM.
module tb_sprite_scanner;

  typedef struct {
    logic [8:0] x;
    logic [8:0] idx;
    logic [2:0] row;
    logic [1:0] pal;
    logic       pri;
    logic       hf;
  } rec_t;

  typedef struct {
    logic [7:0] ln;
    int         slot;
    logic [7:0] y;
    logic [8:0] idx;
    logic [8:0] x;
    logic       h16;
    logic       vf;
    logic       hf;
    logic       pri;
    logic [1:0] pal;
    logic       hit;
    logic [2:0] row;
    logic [8:0] eidx;
  } vec_t;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [7:0] line;
  logic [5:0] spr_sel;
  logic [8:0] spr_x;
  logic [7:0] spr_y;
  logic [8:0] spr_idx;
  logic       spr_enable;
  logic       spr_priority;
  logic [1:0] spr_palette;
  logic       spr_h16;
  logic       spr_vflip;
  logic       spr_hflip;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] out_x;
  logic [8:0] out_idx;
  logic [2:0] out_row;
  logic [1:0] out_palette;
  logic       out_priority;
  logic       out_hflip;
  logic       busy;
  logic       done;
  logic       overflow;

  logic [8:0] m_x   [64];
  logic [7:0] m_y   [64];
  logic [8:0] m_idx [64];
  logic       m_en  [64];
  logic       m_pri [64];
  logic [1:0] m_pal [64];
  logic       m_h16 [64];
  logic       m_vf  [64];
  logic       m_hf  [64];

  assign spr_x        = m_x[spr_sel];
  assign spr_y        = m_y[spr_sel];
  assign spr_idx      = m_idx[spr_sel];
  assign spr_enable   = m_en[spr_sel];
  assign spr_priority = m_pri[spr_sel];
  assign spr_palette  = m_pal[spr_sel];
  assign spr_h16      = m_h16[spr_sel];
  assign spr_vflip    = m_vf[spr_sel];
  assign spr_hflip    = m_hf[spr_sel];

  sprite_scanner #(.MAX_SPRITES(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .line(line), .spr_sel(spr_sel),
    .spr_x(spr_x), .spr_y(spr_y), .spr_idx(spr_idx), .spr_enable(spr_enable),
    .spr_priority(spr_priority), .spr_palette(spr_palette), .spr_h16(spr_h16),
    .spr_vflip(spr_vflip), .spr_hflip(spr_hflip), .out_valid(out_valid),
    .out_ready(out_ready), .out_x(out_x), .out_idx(out_idx), .out_row(out_row),
    .out_palette(out_palette), .out_priority(out_priority), .out_hflip(out_hflip),
    .busy(busy), .done(done), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   total;
  int   bad;
  int   cyc;
  int   start_cyc;
  int   done_cyc;
  int   done_cnt;
  int   first_valid;
  rec_t recs[$];
  vec_t vecs[9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic sample();
    rec_t r;
    if (out_valid && out_ready) begin
      r.x   = out_x;
      r.idx = out_idx;
      r.row = out_row;
      r.pal = out_palette;
      r.pri = out_priority;
      r.hf  = out_hflip;
      recs.push_back(r);
    end
    if (out_valid && !start && first_valid < 0) first_valid = cyc;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  endtask

  // One clock cycle: observe at the falling edge, return just after the rising edge.
  task automatic step();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) begin
      m_x[i] = 9'd0;   m_y[i] = 8'd0;   m_idx[i] = 9'd0;
      m_en[i] = 1'b0;  m_pri[i] = 1'b0; m_pal[i] = 2'd0;
      m_h16[i] = 1'b0; m_vf[i] = 1'b0;  m_hf[i] = 1'b0;
    end
  endtask

  // Start a scan (renderer not ready in the start cycle) and run until done or timeout.
  task automatic run_scan(input logic [7:0] ln, input int stall_from, input int stall_len);
    recs.delete();
    done_cnt    = 0;
    done_cyc    = -1;
    first_valid = -1;
    line        = ln;
    start       = 1'b1;
    out_ready   = 1'b0;
    start_cyc   = cyc;
    step();
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
    for (int i = 0; i < 300 && done_cnt == 0; i++) begin
      out_ready = (i >= stall_from && i < stall_from + stall_len) ? 1'b0 : 1'b1;
      step();
    end
    chk("done_seen", 64'(done_cnt), 64'd1);
    chk("busy_after_done", 64'(busy), 64'd0);
    out_ready = 1'b1;
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0;
    vecs[0] = '{8'd103, 5,  8'd100, 9'h040, 9'h00A, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 3'd3, 9'h040};
    vecs[1] = '{8'd103, 5,  8'd100, 9'h040, 9'h00A, 1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 1'b1, 3'd4, 9'h040};
    vecs[2] = '{8'd110, 12, 8'd100, 9'h1FF, 9'h1FF, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1, 3'd2, 9'h000};
    vecs[3] = '{8'd3,   63, 8'd250, 9'h020, 9'h12C, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 3'd1, 9'h021};
    vecs[4] = '{8'd101, 0,  8'd100, 9'h010, 9'h001, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 3'd6, 9'h011};
    vecs[5] = '{8'd107, 30, 8'd100, 9'h033, 9'h0AB, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 3'd0, 9'h033};
    vecs[6] = '{8'd108, 7,  8'd100, 9'h005, 9'h005, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0, 9'h000};
    vecs[7] = '{8'd116, 7,  8'd100, 9'h005, 9'h005, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0, 9'h000};
    vecs[8] = '{8'd249, 7,  8'd250, 9'h005, 9'h005, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0, 9'h000};

    reset_n = 1'b0; start = 1'b0; line = 8'd0; out_ready = 1'b1;
    clear_mem();
    #12;
    chk("reset_ctrl", 64'({spr_sel, out_valid, busy, done, overflow}), 64'd0);
    chk("reset_data", 64'({out_x, out_idx, out_row, out_palette, out_priority, out_hflip}), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // No visible sprites: pure 64-slot walk.
    run_scan(8'd10, 0, 0);
    chk("nohit_records", 64'(recs.size()), 64'd0);
    chk("nohit_done_latency", 64'(done_cyc - start_cyc), 64'd65);
    chk("nohit_overflow", 64'(overflow), 64'd0);

    // Single-sprite vectors.
    for (int v = 0; v < 9; v++) begin
      clear_mem();
      m_en[vecs[v].slot]  = 1'b1;
      m_y[vecs[v].slot]   = vecs[v].y;
      m_idx[vecs[v].slot] = vecs[v].idx;
      m_x[vecs[v].slot]   = vecs[v].x;
      m_h16[vecs[v].slot] = vecs[v].h16;
      m_vf[vecs[v].slot]  = vecs[v].vf;
      m_hf[vecs[v].slot]  = vecs[v].hf;
      m_pri[vecs[v].slot] = vecs[v].pri;
      m_pal[vecs[v].slot] = vecs[v].pal;
      run_scan(vecs[v].ln, 0, 0);
      chk($sformatf("vec%0d_records", v), 64'(recs.size()), 64'(vecs[v].hit));
      chk($sformatf("vec%0d_done_latency", v), 64'(done_cyc - start_cyc), 64'd65);
      if (vecs[v].hit && recs.size() > 0) begin
        chk($sformatf("vec%0d_fields", v),
            64'({recs[0].x, recs[0].idx, recs[0].row, recs[0].pal, recs[0].pri, recs[0].hf}),
            64'({vecs[v].x, vecs[v].eidx, vecs[v].row, vecs[v].pal, vecs[v].pri, vecs[v].hf}));
        chk($sformatf("vec%0d_valid_latency", v), 64'(first_valid - start_cyc), 64'(vecs[v].slot + 2));
      end
    end

    // Backpressure: three consecutive hits, renderer stalls for 5 cycles.
    clear_mem();
    for (int s = 0; s < 3; s++) begin
      m_en[s] = 1'b1; m_y[s] = 8'd60; m_idx[s] = 9'h100 + 9'(s);
    end
    run_scan(8'd62, 1, 5);
    chk("bp_records", 64'(recs.size()), 64'd3);
    for (int k = 0; k < 3 && k < recs.size(); k++) begin
      chk($sformatf("bp_order%0d", k), 64'(recs[k].idx), 64'(9'h100 + 9'(k)));
    end
    chk("bp_done_latency", 64'(done_cyc - start_cyc), 64'd70);

    // Overflow: 20 visible sprites in slots 2..21.
    clear_mem();
    for (int s = 2; s < 22; s++) begin
      m_en[s] = 1'b1; m_y[s] = 8'd50; m_idx[s] = 9'(s);
    end
    run_scan(8'd50, 0, 0);
    chk("ovf_records", 64'(recs.size()), 64'd16);
    for (int k = 0; k < 16 && k < recs.size(); k++) begin
      chk($sformatf("ovf_order%0d", k), 64'(recs[k].idx), 64'(k + 2));
    end
    chk("ovf_done_latency", 64'(done_cyc - start_cyc), 64'd20);
    chk("ovf_flag", 64'(overflow), 64'd1);
    step(); step(); step();
    chk("ovf_flag_holds", 64'(overflow), 64'd1);
    run_scan(8'd200, 0, 0);
    chk("ovf_cleared", 64'(overflow), 64'd0);

    // Restart with a pending record: it must be dropped.
    clear_mem();
    m_en[0] = 1'b1;  m_y[0] = 8'd10;  m_idx[0] = 9'h0AA;  m_x[0] = 9'h055;  m_pal[0] = 2'd3;
    m_en[40] = 1'b1; m_y[40] = 8'd30; m_idx[40] = 9'h028;
    line = 8'd12; start = 1'b1; out_ready = 1'b0;
    step();
    start = 1'b0;
    step(); step(); step();
    chk("restart_pending", 64'(out_valid), 64'd1);
    run_scan(8'd33, 0, 0);
    chk("restart_records", 64'(recs.size()), 64'd1);
    if (recs.size() > 0) chk("restart_idx", 64'(recs[0].idx), 64'h028);
    chk("restart_valid_latency", 64'(first_valid - start_cyc), 64'd42);

    // Asynchronous reset mid-scan with a record held.
    line = 8'd12; start = 1'b1; out_ready = 1'b0;
    step();
    start = 1'b0;
    step(); step();
    chk("prereset_valid", 64'(out_valid), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("midreset_ctrl", 64'({spr_sel, out_valid, busy, done, overflow}), 64'd0);
    chk("midreset_data", 64'({out_x, out_idx, out_row, out_palette, out_priority, out_hflip}), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    cyc++;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sprite_scanner.md
# sprite_scanner

Per-scanline sprite evaluator that reads the sprite attribute RAM from its read port. On each `start` pulse it walks all 64 sprite slots via `spr_sel` and tests each sprite's Y range against the target line. For every visible sprite it emits one record over a valid/ready stream to the sprite line renderer, up to `MAX_SPRITES` per line, and flags overflow when more are visible. It sits between the sprite attribute store and the line-buffer renderer in the video block.

## Interface
Parameters:
- `MAX_SPRITES`, default 16: maximum records emitted per line (1..64).

Ports:
- `clk`  in  1  video clock; the block has one clock.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  single-cycle pulse that begins a scan; legal in any state.
- `line`  in  8  target scanline, sampled only when `start` is high.
- `spr_sel`  out  6  attribute RAM read address (sprite slot).
- `spr_x` (9), `spr_y` (8), `spr_idx` (9), `spr_enable`, `spr_priority`, `spr_palette` (2), `spr_h16`, `spr_vflip`, `spr_hflip`  in  attributes of slot `spr_sel`, valid combinationally in the same cycle.
- `out_valid`  out  1  record available.
- `out_ready`  in  1  renderer accepts the record.
- `out_x`  out  9  sprite X.
- `out_idx`  out  9  tile index, corrected for the lower half of 16-high sprites.
- `out_row`  out  3  pixel row within the tile, after vflip.
- `out_palette` (2), `out_priority` (1), `out_hflip` (1)  out  passed through from the attributes.
- `busy`  out  1  high from the cycle after `start` until `done`.
- `done`  out  1  one-cycle pulse when the scan has finished and the last record has been accepted.
- `overflow`  out  1  more than `MAX_SPRITES` visible sprites were found; holds until the next `start`.

## Operation
- States: IDLE, SCAN, DRAIN.
- `start` in any state does the following on the next edge:
  - latch `line`;
  - set `spr_sel`=0, hit count=0, `overflow`=0, `out_valid`=0 (a pending record is discarded);
  - go to SCAN.
- Hit test, evaluated combinationally on the current slot:
  - diff = (line_q − `spr_y`) mod 256;
  - height = `spr_h16` ? 16 : 8;
  - hit = `spr_enable` && diff < height. Y wraps, so sprites with `spr_y` > 240 are visible on the top lines.
- Row: r = `spr_vflip` ? (height−1−diff) : diff, 4 bits.
  - `out_row` = r[2:0].
  - `out_idx` = (`spr_idx` + r[3]) mod 512.
- SCAN, each cycle:
  - If there is no hit, advance.
  - If there is a hit and the output register is free (out_valid=0, or out_valid && out_ready this cycle), load the record, set out_valid, increment the count and advance.
  - If there is a hit and the output register is occupied and not being accepted, stall: hold `spr_sel` and all state.
  - If there is a hit and count == `MAX_SPRITES`, set `overflow`=1, load nothing, and go to DRAIN.
  - Advancing from slot 63 goes to DRAIN instead of wrapping.
- DRAIN: when out_valid=0, or the record is being accepted this cycle, go to IDLE and pulse `done` on that edge.
- Output register:
  - out_valid clears on accept unless it is reloaded in the same cycle.
  - Data fields change only on load.

## Timing
- Reset values: `spr_sel`=0, `out_valid`=0, all out_* data=0, `busy`=0, `done`=0, `overflow`=0, state IDLE.
- With `start` high at edge T:
  - slot k is presented on `spr_sel` during cycle T+1+k (no stalls);
  - a hit on slot k gives `out_valid` high from T+2+k.
- With `out_ready` held high and no overflow, the scan takes exactly 64 cycles. `done` pulses in cycle T+65, with `busy` high from T+1 to T+65.
- Each stall cycle adds exactly one cycle to the scan.
- The record stream preserves slot order; the lowest slot is emitted first.
- `reset_n` asserted mid-scan returns every output to its reset value immediately, asynchronously.

## Test plan
- **No hits:** all `spr_enable`=0, `start` with line=10, `out_ready`=1 → no `out_valid`, `done` exactly 65 cycles after `start`, `overflow`=0.
- **Single 8-high sprite and flip:** slot 5, `spr_y`=100, `spr_idx`=0x40, line=103 → one record, `out_row`=3, `out_idx`=0x40. Repeat with `spr_vflip`=1 → `out_row`=4.
- **16-high lower half and Y wrap:**
  - `spr_h16`=1, `spr_y`=100, `spr_idx`=0x1FF, line=110 → `out_idx`=0x000, `out_row`=2.
  - `spr_y`=250, line=3 with 16-high → hit, diff 9.
- **Backpressure:** slots 0, 1 and 2 all hit, `out_ready` low for 5 cycles, then high → records arrive in order 0, 1, 2 with no loss or duplication, and `done` is delayed by the stall cycles.
- **Overflow:** 20 enabled sprites on the line, `MAX_SPRITES`=16 → 16 records, `overflow`=1, `done` pulses after the 16th is accepted, and `overflow` clears on the next `start`.
- **Restart/reset:** `start` issued mid-scan with a pending record → that record is dropped and the scan restarts at slot 0. Deasserting `reset_n` mid-scan → all outputs are immediately at their reset values.
